// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern transmitter.
//   - seq_gen_state_t : FSM state encoding (IDLE=0, SHIFT=1, GAP=2)
//   - SEQ_DEFAULT_W / SEQ_DEFAULT_CNT_W : default widths
//   - eff_len()       : frame length after clamping 0 / oversize values to W
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } seq_gen_state_t;

    localparam int SEQ_DEFAULT_W     = 8;
    localparam int SEQ_DEFAULT_CNT_W = 4;

    // A length of zero, or one larger than the pattern register, means
    // "send the whole pattern".
    function automatic int eff_len(input int len, input int w);
        if (len == 0 || len > w) begin
            return w;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// -----------------------------------------------------------------------------
// seq_piso
// Parallel-in / serial-out register with a down-counting bit index.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   i_load          : capture i_pattern / i_len, index <- i_len-1
//   i_pattern       : parallel frame bits
//   i_len           : effective frame length (already clamped, 1..W)
//   i_shift         : index <- index-1
//   i_reload        : index <- captured length-1 (start of a repeated frame)
//   o_bit_next      : bit that the index will select after this edge; lets
//                     the owner register the serial output one cycle ahead
//   o_last          : current index is 0 (final bit of the frame)
// -----------------------------------------------------------------------------
module seq_piso #(
    parameter int W     = 8,
    parameter int LEN_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [W-1:0]     i_pattern,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_shift,
    input  logic             i_reload,
    output logic             o_bit_next,
    output logic             o_last
);

    logic [W-1:0]     r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;

    logic [W-1:0]     w_pat_next;
    logic [LEN_W-1:0] w_len_next;
    logic [LEN_W-1:0] w_idx_next;
    logic [W-1:0]     w_sel;

    always_comb begin
        w_pat_next = r_pat;
        w_len_next = r_len;
        w_idx_next = r_idx;
        if (i_load) begin
            w_pat_next = i_pattern;
            w_len_next = i_len;
            w_idx_next = i_len - 1'b1;
        end else if (i_reload) begin
            w_idx_next = r_len - 1'b1;
        end else if (i_shift) begin
            w_idx_next = r_idx - 1'b1;
        end
    end

    // Shift instead of a direct index so an index wider than log2(W) stays
    // well defined.
    assign w_sel      = w_pat_next >> w_idx_next;
    assign o_bit_next = w_sel[0];
    assign o_last     = (r_idx == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat <= '0;
            r_len <= '0;
            r_idx <= '0;
        end else begin
            r_pat <= w_pat_next;
            r_len <= w_len_next;
            r_idx <= w_idx_next;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen
// Serial pattern transmitter. On an accepted start, sends the low eff_len bits
// of pattern MSB-first, reps times, with one forced-zero gap cycle between
// frames. All outputs come straight from flops.
// Ports:
//   clk      : clock (rising edge)
//   rst      : asynchronous active-low reset
//   start    : single-cycle request, honoured only in IDLE
//   pattern  : frame bits (W)
//   len      : frame length (LEN_W); 0 or >W means W
//   reps     : repetition count (CNT_W); 0 just pulses done
//   x        : serial data bit (0 when not valid)
//   x_valid  : x carries a frame bit
//   busy     : transfer in progress
//   done     : one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_gen
    import seq_pkg::*;
#(
    parameter int W     = SEQ_DEFAULT_W,
    parameter int CNT_W = SEQ_DEFAULT_CNT_W,
    parameter int LEN_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    seq_gen_state_t   r_state;
    seq_gen_state_t   w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic r_x, r_x_valid, r_busy, r_done;
    logic w_x_next, w_x_valid_next, w_busy_next, w_done_next;

    logic             w_load, w_shift, w_reload;
    logic             w_bit_next, w_last;
    logic [LEN_W-1:0] w_eff_len;

    assign w_eff_len = LEN_W'(eff_len(int'(len), W));

    seq_piso #(
        .W     (W),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_pattern  (pattern),
        .i_len      (w_eff_len),
        .i_shift    (w_shift),
        .i_reload   (w_reload),
        .o_bit_next (w_bit_next),
        .o_last     (w_last)
    );

    // Next-state and next-output logic. Outputs are computed for the cycle
    // after the edge and registered, so r_state always describes the cycle
    // currently visible on the outputs.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        w_reload       = 1'b0;
        w_x_next       = 1'b0;
        w_x_valid_next = 1'b0;
        w_busy_next    = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        w_load         = 1'b1;
                        w_cnt_next     = reps;
                        w_state_next   = ST_SHIFT;
                        w_x_next       = w_bit_next;
                        w_x_valid_next = 1'b1;
                        w_busy_next    = 1'b1;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_shift        = 1'b1;
                    w_x_next       = w_bit_next;
                    w_x_valid_next = 1'b1;
                    w_busy_next    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                    if (r_cnt != CNT_W'(1)) begin
                        w_state_next = ST_GAP;
                        w_busy_next  = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                w_reload       = 1'b1;
                w_state_next   = ST_SHIFT;
                w_x_next       = w_bit_next;
                w_x_valid_next = 1'b1;
                w_busy_next    = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_x       <= w_x_next;
            r_x_valid <= w_x_valid_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen
// Directed bench for seq_gen (W=8, CNT_W=4). Each transfer is described by its
// inputs plus the expected x / x_valid stream over the busy cycles; the bench
// checks {x, x_valid, busy, done} every cycle, then the done cycle.
// -----------------------------------------------------------------------------
module tb_seq_gen;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(W + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic             x, x_valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    seq_gen #(
        .W     (W),
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [7:0]   pattern;
        logic [3:0]   len;
        logic [3:0]   reps;
        int           n;      // busy cycles
        logic [31:0]  ex;     // expected x, bit n-1 = first cycle
        logic [31:0]  ev;     // expected x_valid, same ordering
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(string name, logic [7:0] p, logic [3:0] l,
                                logic [3:0] r, int n, logic [31:0] ex,
                                logic [31:0] ev);
        vec_t v;
        v.name = name; v.pattern = p; v.len = l; v.reps = r;
        v.n = n; v.ex = ex; v.ev = ev;
        return v;
    endfunction

    // Compares {x, x_valid, busy, done} against the expected tuple.
    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {x, x_valid, busy, done};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: {x,x_valid,busy,done} got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Entered at the negedge of busy cycle 1; returns at the negedge of the
    // done cycle after checking it.
    task automatic check_stream(input string name, input int n,
                                input logic [31:0] ex, input logic [31:0] ev);
        for (int k = 0; k < n; k++) begin
            check(name, {ex[n-1-k], ev[n-1-k], 1'b1, 1'b0});
            @(negedge clk);
        end
        check({name, "_done"}, 4'b0001);
    endtask

    task automatic drive_start(input logic [7:0] p, input logic [3:0] l,
                               input logic [3:0] r);
        start   = 1'b1;
        pattern = p;
        len     = l;
        reps    = r;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_start(v.pattern, v.len, v.reps);
        check_stream(v.name, v.n, v.ex, v.ev);
        @(negedge clk);
        check({v.name, "_idle"}, 4'b0000);
        $display("txn %-10s pattern=%h len=%0d reps=%0d busy_cycles=%0d",
                 v.name, v.pattern, v.len, v.reps, v.n);
    endtask

    initial begin
        vecs[0] = mk("e0_len8",  8'hE0, 4'd8,  4'd1, 8,  32'b11100000,    32'b11111111);
        vecs[1] = mk("07_x3",    8'h07, 4'd3,  4'd3, 11, 32'b11101110111, 32'b11101110111);
        vecs[2] = mk("len0",     8'hA5, 4'd0,  4'd1, 8,  32'b10100101,    32'b11111111);
        vecs[3] = mk("len12",    8'hA5, 4'd12, 4'd1, 8,  32'b10100101,    32'b11111111);
        vecs[4] = mk("reps0",    8'hFF, 4'd8,  4'd0, 0,  32'b0,           32'b0);
        vecs[5] = mk("110_x2",   8'h06, 4'd3,  4'd2, 7,  32'b1100110,     32'b1110111);
        vecs[6] = mk("len1_x2",  8'hFF, 4'd1,  4'd2, 3,  32'b101,         32'b101);
        vecs[7] = mk("len2",     8'h02, 4'd2,  4'd1, 2,  32'b10,          32'b11);

        rst = 1'b0; start = 1'b0; pattern = '0; len = '0; reps = '0;
        @(negedge clk);
        check("reset", 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset", 4'b0000);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // start pulsed in SHIFT cycle 3 with different inputs must be ignored
        @(negedge clk);
        drive_start(8'hE0, 4'd8, 4'd1);
        for (int k = 0; k < 8; k++) begin
            check("ign_start", {(k < 3) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0});
            start   = (k == 2);
            pattern = 8'h0F;
            len     = 4'd4;
            reps    = 4'd2;
            @(negedge clk);
            start = 1'b0;
        end
        check("ign_start_done", 4'b0001);
        @(negedge clk);
        check("ign_start_idle", 4'b0000);
        $display("txn ign_start  start in SHIFT cycle 3 ignored");

        // asynchronous reset between edges during bit 4 of 8
        @(negedge clk);
        drive_start(8'hFF, 4'd8, 4'd1);
        repeat (3) @(negedge clk);
        check("pre_abort", 4'b1110);
        #2 rst = 1'b0;
        #1 check("abort_immediate", 4'b0000);
        @(negedge clk);
        check("abort_held", 4'b0000);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 4'b0000);
        end
        $display("txn abort      reset mid-frame, outputs cleared, no done");
        run_vec(mk("after_rst", 8'hC3, 4'd8, 4'd1, 8, 32'b11000011, 32'b11111111));

        // back-to-back: second start in the done cycle of the first
        @(negedge clk);
        drive_start(8'h05, 4'd3, 4'd1);
        check_stream("b2b_a", 3, 32'b101, 32'b111);
        drive_start(8'h06, 4'd3, 4'd1);
        check_stream("b2b_b", 3, 32'b110, 32'b111);
        @(negedge clk);
        check("b2b_idle", 4'b0000);
        $display("txn b2b       two frames with start in done cycle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: the driving end of the single-bit serial stream consumed by the team's Moore/Mealy sequence detectors. On a start request it captures a parallel pattern, then shifts its low `len` bits out MSB-first, one bit per clock, repeating the frame `reps` times. Between repetitions it drives one forced-zero gap cycle, so a downstream detector returns to its idle state between frames. It sits between the test/control logic and the detector's `x` input.

## Interface
- `W`, default 8: maximum pattern width in bits (2..32).
- `CNT_W`, default 4: width of the repetition count.
- `LEN_W`, default `$clog2(W+1)`: width of `len`.

- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `start` input 1: single-cycle request. Sampled only in IDLE.
- `pattern` input W: frame bits. Captured on an accepted `start`.
- `len` input LEN_W: frame length in bits. Captured with `pattern`.
- `reps` input CNT_W: number of frame repetitions. Captured with `pattern`.
- `x` output 1: serial data bit.
- `x_valid` output 1: high on every cycle where `x` carries a frame bit.
- `busy` output 1: high from the cycle after an accepted `start` until the last bit has been sent.
- `done` output 1: one-cycle pulse marking completion.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE, `start`=1 with `reps`≠0:
  - Capture `pattern`, the effective length and `reps`.
  - Bit index ← eff_len−1; repetition counter ← `reps`; go to SHIFT.
- Effective length:
  - `len`=0 or `len`>W is clamped to W.
  - Otherwise it equals `len`.
- IDLE, `start`=1 with `reps`=0: no SHIFT cycles. `done` pulses the next cycle and the FSM stays in IDLE.
- SHIFT, each cycle:
  - `x` = captured_pattern[bit index], `x_valid`=1, `busy`=1.
  - Bit index decrements every cycle.
- SHIFT, on bit index 0:
  - Repetition counter decrements.
  - If the new count is ≠0: go to GAP.
  - Else: go to IDLE with `done`=1 on the following cycle.
- GAP: exactly one cycle with `x`=0, `x_valid`=0, `busy`=1. Bit index reloads to eff_len−1; go to SHIFT.
- `start` while not in IDLE is ignored. Captured values are not disturbed.
- `x` is 0 whenever `x_valid`=0.
- Counter widths:
  - The bit index is LEN_W wide.
  - The repetition counter is CNT_W wide, so the maximum is 2^CNT_W−1 repetitions.
  - Neither counter wraps: the transitions above prevent it.
- Reset asserted mid-frame aborts the frame immediately:
  - FSM → IDLE.
  - `x`, `x_valid`, `busy`, `done` all → 0.
  - No `done` is issued for the aborted frame.

## Timing
- Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0, FSM=IDLE, all counters 0.
- All outputs are registered; no combinational path from any input to any output.
- `start` accepted at edge t:
  - First frame bit appears on `x` in cycle t+1.
  - `busy` rises in cycle t+1.
- One frame = eff_len cycles. Total busy duration = reps·eff_len + (reps−1) cycles.
- `done` is high in the single cycle after the final frame bit, coincident with `busy`=0.
- A new `start` is accepted in the `done` cycle, since the FSM is already in IDLE. This allows back-to-back transfers with no dead cycle beyond `done`.

## Structure
- Shared package `seq_pkg`:
  - FSM state encoding `seq_gen_state_t` (IDLE=0, SHIFT=1, GAP=2).
  - Default widths.
  - The length-clamp function `eff_len(len, W)`.
- One sub-module, `seq_piso`: a parallel-in/serial-out shift register with the down-counting bit index.
  - Inputs: load, shift enable, reload.
  - Output: last-bit flag.
  - `seq_gen` owns the FSM, the repetition counter and the output registers.

## Test plan
- Reset, then `pattern`=8'hE0, `len`=8, `reps`=1, `start`: cycles 1..8 show `x` = 1,1,1,0,0,0,0,0 with `x_valid`=1; `done` in cycle 9; `busy` high only in cycles 1..8.
- `pattern`=8'h07, `len`=3, `reps`=3: `x` = 111,gap,111,gap,111 over 11 busy cycles; `x_valid`=0 in gap cycles 4 and 8; a detector for 111 sees three separate matches.
- `len`=0 and `len`=12 with W=8: both send all 8 bits; `reps`=0 gives `done` in cycle t+1 with `busy` never high.
- `start` pulsed in SHIFT cycle 3 with different `pattern`/`len`: ignored; the original frame completes unchanged.
- `rst` asserted asynchronously mid-frame (between clock edges, bit 4 of 8): all outputs 0 immediately; no `done`; after release, a fresh `start` transmits correctly.
- Back-to-back: `start` asserted in the `done` cycle; the second frame's first bit follows in the next cycle with no extra idle cycle.
